seg7_display_ctrl: RTL and testbench

Parametrised seven-segment display controller for the MIPS core. It captures either the ALU result or the RAM read data on a load strobe and converts it sequentially with a shift-add-3 (double-dabble) engine, replacing per-digit divide/modulo logic. It supports decimal or hex mode, signed decimal with a minus sign, leading-zero blanking and an overflow flag. It drives NUM_DIGITS registered segment digits to the board displays.

---
 rtl/seg7_display_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_seg7_display_ctrl.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/seg7_display_ctrl.sv
// Seven-segment display controller: captures ALU/RAM word, converts with double-dabble (decimal) or direct nibbles (hex).
// Latency: decimal seg/overflow valid after load edge + DATA_W + 1 clocks; hex after load edge + 1.
// Backpressure: load is only accepted while idle; a load seen while busy is dropped, never queued.
module seg7_display_ctrl #(
  parameter int DATA_W     = 32,
  parameter int NUM_DIGITS = 8,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic                    MemtoReg,
  input  logic [DATA_W-1:0]       ALU_result,
  input  logic [DATA_W-1:0]       RAM_Read_Data,
  input  logic                    mode_hex,
  input  logic                    signed_en,
  input  logic                    blank_lz,
  output logic [7*NUM_DIGITS-1:0] seg,
  output logic                    busy,
  output logic                    overflow
);

  // Decimal digits needed for 2^DATA_W-1 (floor(DATA_W*log10(2))+1), hex nibbles, and working digit span.
  localparam int BCD_N = (DATA_W * 1233) / 4096 + 1;
  localparam int HEX_N = (DATA_W + 3) / 4;
  localparam int SRC_N = (BCD_N > HEX_N) ? BCD_N : HEX_N;
  localparam int L     = (SRC_N > NUM_DIGITS) ? SRC_N : NUM_DIGITS;
  localparam int CNT_W = $clog2(DATA_W + 1);

  localparam logic [6:0] SEG_MINUS = (ACTIVE_LOW != 0) ? 7'b0111111 : 7'b1000000;
  localparam logic [6:0] SEG_BLANK = (ACTIVE_LOW != 0) ? 7'b1111111 : 7'b0000000;
  localparam logic [6:0] SEG_ZERO  = (ACTIVE_LOW != 0) ? 7'b1000000 : 7'b0111111;

  typedef enum logic [1:0] {IDLE, CONV, UPDATE} state_t;

  state_t                   state_q, state_d;
  logic [DATA_W-1:0]        mag_q, mag_d;
  logic [4*BCD_N-1:0]       bcd_q, bcd_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     hex_q, hex_d;
  logic                     neg_q, neg_d;
  logic                     blank_q, blank_d;
  logic [7*NUM_DIGITS-1:0]  seg_q, seg_d;
  logic                     ovf_q, ovf_d;

  logic [DATA_W-1:0]        src;
  logic                     src_neg;
  logic [4*BCD_N-1:0]       bcd_adj;
  logic [4*HEX_N-1:0]       hex_pad;
  logic [3:0]               dig [L];
  int                       msd;
  int                       need;
  logic                     ovf_new;
  logic [7*NUM_DIGITS-1:0]  seg_new;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'h0: g = 7'b1000000;
      4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;
      4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;
      4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;
      4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0010000;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b0000011;
      4'hC: g = 7'b1000110;
      4'hD: g = 7'b0100001;
      4'hE: g = 7'b0000110;
      default: g = 7'b0001110;
    endcase
    return (ACTIVE_LOW != 0) ? g : ~g;
  endfunction

  // State and datapath registers; reset aborts any conversion and shows "0" everywhere.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      mag_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      hex_q   <= 1'b0;
      neg_q   <= 1'b0;
      blank_q <= 1'b0;
      seg_q   <= {NUM_DIGITS{SEG_ZERO}};
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      hex_q   <= hex_d;
      neg_q   <= neg_d;
      blank_q <= blank_d;
      seg_q   <= seg_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state logic: decimal spends exactly DATA_W clocks in CONV, hex goes straight to UPDATE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load) state_d = mode_hex ? UPDATE : CONV;
      CONV:    if (cnt_q == CNT_W'(1)) state_d = UPDATE;
      UPDATE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Source select and magnitude; negative decimal values are negated as unsigned so the most negative value works.
  always_comb begin
    src     = MemtoReg ? RAM_Read_Data : ALU_result;
    src_neg = !mode_hex && signed_en && src[DATA_W-1];
  end

  // Double-dabble step: add 3 to every BCD nibble >= 5 before the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < BCD_N; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // Digit extraction, leading-digit search, overflow and glyph placement for the UPDATE cycle.
  always_comb begin
    hex_pad = '0;
    hex_pad[DATA_W-1:0] = mag_q;
    for (int i = 0; i < L; i++) dig[i] = 4'h0;
    if (hex_q) begin
      for (int i = 0; i < HEX_N; i++) dig[i] = hex_pad[4*i +: 4];
    end else begin
      for (int i = 0; i < BCD_N; i++) dig[i] = bcd_q[4*i +: 4];
    end
    msd = 0;
    for (int i = 0; i < L; i++) begin
      if (dig[i] != 4'h0) msd = i;
    end
    need    = msd + 1 + (neg_q ? 1 : 0);
    ovf_new = (need > NUM_DIGITS);
    seg_new = '0;
    for (int p = 0; p < NUM_DIGITS; p++) begin
      seg_new[7*p +: 7] = glyph(dig[p]);
      if (blank_q && (p > msd)) seg_new[7*p +: 7] = SEG_BLANK;
      if (neg_q && !ovf_new) begin
        if (blank_q ? (p == msd + 1) : (p == NUM_DIGITS - 1)) seg_new[7*p +: 7] = SEG_MINUS;
      end
    end
  end

  // Datapath next values per state.
  always_comb begin
    mag_d   = mag_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    hex_d   = hex_q;
    neg_d   = neg_q;
    blank_d = blank_q;
    seg_d   = seg_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          mag_d   = src_neg ? (~src + DATA_W'(1)) : src;
          bcd_d   = '0;
          cnt_d   = CNT_W'(DATA_W);
          hex_d   = mode_hex;
          neg_d   = src_neg;
          blank_d = blank_lz;
        end
      end
      CONV: begin
        bcd_d = {bcd_adj[4*BCD_N-2:0], mag_q[DATA_W-1]};
        mag_d = {mag_q[DATA_W-2:0], 1'b0};
        cnt_d = cnt_q - CNT_W'(1);
      end
      UPDATE: begin
        seg_d = seg_new;
        ovf_d = ovf_new;
      end
      default: ;
    endcase
  end

  // Outputs come straight from registers.
  always_comb begin
    busy     = (state_q != IDLE);
    seg      = seg_q;
    overflow = ovf_q;
  end

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// Directed bench for seg7_display_ctrl with DATA_W=32, NUM_DIGITS=8, active-low segments.
// Each step loads a value, counts busy clocks, then compares seg/overflow to hand-built glyphs.
// Loads issued while busy must be dropped.
module tb_seg7_display_ctrl;

  localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100, G3 = 7'b0110000;
  localparam logic [6:0] G4 = 7'b0011001, G5 = 7'b0010010, G6 = 7'b0000010, G7 = 7'b1111000;
  localparam logic [6:0] G8 = 7'b0000000, G9 = 7'b0010000;
  localparam logic [6:0] GA = 7'b0001000, GB = 7'b0000011, GC = 7'b1000110, GD = 7'b0100001;
  localparam logic [6:0] GE = 7'b0000110, GF = 7'b0001110;
  localparam logic [6:0] GM = 7'b0111111, GX = 7'b1111111;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load = 1'b0;
  logic        MemtoReg = 1'b0;
  logic [31:0] ALU_result = '0;
  logic [31:0] RAM_Read_Data = '0;
  logic        mode_hex = 1'b0;
  logic        signed_en = 1'b0;
  logic        blank_lz = 1'b0;
  logic [55:0] seg;
  logic        busy;
  logic        overflow;

  int vectors = 0;
  int fails = 0;
  int n;

  seg7_display_ctrl #(.DATA_W(32), .NUM_DIGITS(8), .ACTIVE_LOW(1)) dut (
    .clk(clk), .reset(reset), .load(load), .MemtoReg(MemtoReg),
    .ALU_result(ALU_result), .RAM_Read_Data(RAM_Read_Data),
    .mode_hex(mode_hex), .signed_en(signed_en), .blank_lz(blank_lz),
    .seg(seg), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [55:0] disp(input logic [6:0] d7, d6, d5, d4, d3, d2, d1, d0);
    return {d7, d6, d5, d4, d3, d2, d1, d0};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one load pulse; the unselected source carries the complement so a wrong mux shows up.
  task automatic do_load(input logic msel, input logic [31:0] val, input logic hx, input logic sg, input logic bz);
    @(negedge clk);
    MemtoReg      = msel;
    ALU_result    = msel ? ~val : val;
    RAM_Read_Data = msel ? val : ~val;
    mode_hex      = hx;
    signed_en     = sg;
    blank_lz      = bz;
    load          = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
  endtask

  // Count negedges with busy high after the load edge, bounded.
  task automatic wait_done(output int cnt);
    cnt = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!busy) break;
      cnt++;
    end
  endtask

  task automatic run(input string tag, input logic msel, input logic [31:0] val, input logic hx,
                     input logic sg, input logic bz, input int exp_cyc, input logic [55:0] exp_seg,
                     input logic exp_ovf);
    int c;
    do_load(msel, val, hx, sg, bz);
    wait_done(c);
    chk({tag, "_cycles"}, 64'(c), 64'(exp_cyc));
    chk({tag, "_seg"}, 64'(seg), 64'(exp_seg));
    chk({tag, "_ovf"}, 64'(overflow), 64'(exp_ovf));
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_seg", 64'(seg), 64'({8{G0}}));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_ovf", 64'(overflow), 64'(0));
    @(negedge clk) reset = 1'b1;

    // Reset in the middle of a conversion
    do_load(1'b0, 32'd12345678, 1'b0, 1'b0, 1'b0);
    repeat (10) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort_seg", 64'(seg), 64'({8{G0}}));
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_ovf", 64'(overflow), 64'(0));
    @(negedge clk) reset = 1'b1;
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy) n++;
    end
    chk("abort_idle", 64'(n), 64'(0));
    chk("abort_hold", 64'(seg), 64'({8{G0}}));

    // Decimal conversions
    run("dec_12345678", 1'b0, 32'd12345678, 1'b0, 1'b0, 1'b0, 33, disp(G1, G2, G3, G4, G5, G6, G7, G8), 1'b0);
    run("dec_neg123_blank", 1'b1, 32'hFFFFFF85, 1'b0, 1'b1, 1'b1, 33, disp(GX, GX, GX, GX, GM, G1, G2, G3), 1'b0);
    run("dec_neg123_pad", 1'b1, 32'hFFFFFF85, 1'b0, 1'b1, 1'b0, 33, disp(GM, G0, G0, G0, G0, G1, G2, G3), 1'b0);
    run("dec_ffffffff", 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 33, disp(G9, G4, G9, G6, G7, G2, G9, G5), 1'b1);
    run("dec_min_int", 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0, 33, disp(G4, G7, G4, G8, G3, G6, G4, G8), 1'b1);
    run("dec_neg9999999", 1'b0, 32'hFF676981, 1'b0, 1'b1, 1'b1, 33, disp(GM, G9, G9, G9, G9, G9, G9, G9), 1'b0);
    run("dec_neg10000000", 1'b0, 32'hFF676980, 1'b0, 1'b1, 1'b1, 33, disp(G1, G0, G0, G0, G0, G0, G0, G0), 1'b1);
    run("dec_zero_blank", 1'b1, 32'd0, 1'b0, 1'b1, 1'b1, 33, disp(GX, GX, GX, GX, GX, GX, GX, G0), 1'b0);
    run("dec_unsigned_msb", 1'b0, 32'h80000000, 1'b0, 1'b0, 1'b1, 33, disp(G4, G7, G4, G8, G3, G6, G4, G8), 1'b1);

    // Hex conversions
    run("hex_blank", 1'b0, 32'h00ABCDEF, 1'b1, 1'b0, 1'b1, 1, disp(GX, GX, GA, GB, GC, GD, GE, GF), 1'b0);
    run("hex_noblank_signed", 1'b1, 32'h00ABCDEF, 1'b1, 1'b1, 1'b0, 1, disp(G0, G0, GA, GB, GC, GD, GE, GF), 1'b0);
    run("hex_full_neg", 1'b0, 32'hF0123456, 1'b1, 1'b1, 1'b1, 1, disp(GF, G0, G1, G2, G3, G4, G5, G6), 1'b0);

    // Load while busy is dropped
    do_load(1'b0, 32'd42, 1'b0, 1'b0, 1'b1);
    n = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      if (n == 5) begin
        ALU_result = 32'd99;
        load = 1'b1;
      end else begin
        load = 1'b0;
      end
    end
    load = 1'b0;
    chk("busy_load_cycles", 64'(n), 64'(33));
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy) n++;
    end
    chk("busy_load_no_requeue", 64'(n), 64'(0));
    chk("busy_load_seg", 64'(seg), 64'(disp(GX, GX, GX, GX, GX, GX, G4, G2)));
    run("after_busy_99", 1'b0, 32'd99, 1'b0, 1'b0, 1'b1, 33, disp(GX, GX, GX, GX, GX, GX, G9, G9), 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
